// File: rtl/fp_pkg.sv
// fp_pkg: shared rounding modes, operand classes, flag indices
// and format helpers for the pipelined IEEE-754 arithmetic units.
package fp_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rm_e;

   typedef enum logic [2:0] {
      CL_ZERO,
      CL_SUB,
      CL_NORM,
      CL_INF,
      CL_QNAN,
      CL_SNAN
   } cls_e;

   localparam int FL_INX = 0;
   localparam int FL_UDF = 1;
   localparam int FL_OVF = 2;
   localparam int FL_INV = 3;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic logic [127:0] fp_qnan(input int exp_w,
                                            input int man_w);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
      w[man_w - 1] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalised significand with G/R/S bits,
// handles carry-out, overflow and underflow, and packs the word.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 sign,
   input  logic [EXP_W+1:0]     exp_in,
   input  logic [MAN_W:0]       sig,
   input  logic                 g,
   input  logic                 r,
   input  logic                 s,
   input  rm_e                  rm,
   output logic [EXP_W+MAN_W:0] word,
   output logic [3:0]           flags
);

   localparam int EW2 = EXP_W + 2;
   localparam logic signed [EW2-1:0] E_ONE = EW2'(1);
   localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

   logic                  inx;
   logic                  inc;
   logic                  carry;
   logic                  to_inf;
   logic [MAN_W+1:0]      rnd;
   logic signed [EW2-1:0] exp_r;
   logic                  unused_hid;

   assign unused_hid = rnd[MAN_W];

   // Round by mode, renormalise on carry, then clamp to zero/inf/max.
   always_comb begin
      inx = g | r | s;
      inc = 1'b0;
      unique case (rm)
         RM_RNE:  inc = g & (r | s | sig[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = ~sign & inx;
         RM_RDN:  inc = sign & inx;
         default: inc = 1'b0;
      endcase
      rnd    = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
      carry  = rnd[MAN_W+1];
      exp_r  = exp_in + {{(EW2-1){1'b0}}, carry};
      to_inf = (rm == RM_RNE)
             | ((rm == RM_RUP) & ~sign)
             | ((rm == RM_RDN) & sign);
      word   = {sign, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
      flags  = '0;
      flags[FL_INX] = inx;
      if (exp_r < E_ONE) begin
         word = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags[FL_UDF] = 1'b1;
         flags[FL_INX] = 1'b1;
      end else if (exp_r >= E_MAX) begin
         flags[FL_OVF] = 1'b1;
         flags[FL_INX] = 1'b1;
         if (to_inf)
            word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else
            word = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754 multiplier with valid/ready
// backpressure, runtime rounding mode and exception flags.
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [1:0]           rm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [3:0]           flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));
   localparam logic [W-1:0]   QNAN = W'(fp_qnan(EXP_W, MAN_W));

   function automatic cls_e classify(input logic [EXP_W-1:0] e,
                                     input logic [MAN_W-1:0] f);
      if (e == '0) return (f == '0) ? CL_ZERO : CL_SUB;
      if (e == '1) begin
         if (f == '0) return CL_INF;
         return f[MAN_W-1] ? CL_QNAN : CL_SNAN;
      end
      return CL_NORM;
   endfunction

   logic advance;
   cls_e ca, cb;
   logic za, zb, ia, ib, na, nb;

   logic           v1_q, v1_d, sg1_q, sg1_d, sp1_q, sp1_d;
   logic [EW2-1:0] e1_q, e1_d;
   logic [MAN_W:0] ma1_q, ma1_d, mb1_q, mb1_d;
   logic [W-1:0]   sw1_q, sw1_d;
   logic [3:0]     sf1_q, sf1_d;
   rm_e            rm1_q, rm1_d;

   logic           v2_q, v2_d, sg2_q, sg2_d, sp2_q, sp2_d;
   logic [EW2-1:0] e2_q, e2_d;
   logic [PW-1:0]  p2_q, p2_d;
   logic [W-1:0]   sw2_q, sw2_d;
   logic [3:0]     sf2_q, sf2_d;
   rm_e            rm2_q, rm2_d;

   logic [EW2-1:0] n_exp;
   logic [MAN_W:0] n_sig;
   logic           n_g, n_r, n_s;
   logic [W-1:0]   rp_word;
   logic [3:0]     rp_flags;

   logic           ov_q, ov_d;
   logic [W-1:0]   res_q, res_d;
   logic [3:0]     fl_q, fl_d;

   assign advance   = en & (~ov_q | out_ready);
   assign in_ready  = advance;
   assign out_valid = ov_q;
   assign result    = res_q;
   assign flags     = fl_q;

   // S1: classify operands, resolve specials, sum exponents.
   always_comb begin
      ca = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
      cb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
      za = (ca == CL_ZERO) || (ca == CL_SUB);
      zb = (cb == CL_ZERO) || (cb == CL_SUB);
      ia = (ca == CL_INF);
      ib = (cb == CL_INF);
      na = (ca == CL_QNAN) || (ca == CL_SNAN);
      nb = (cb == CL_QNAN) || (cb == CL_SNAN);
      v1_d  = v1_q;
      sg1_d = sg1_q;
      e1_d  = e1_q;
      ma1_d = ma1_q;
      mb1_d = mb1_q;
      rm1_d = rm1_q;
      sp1_d = sp1_q;
      sw1_d = sw1_q;
      sf1_d = sf1_q;
      if (advance) begin
         v1_d  = in_valid;
         sg1_d = a[W-1] ^ b[W-1];
         e1_d  = {2'b00, a[W-2:MAN_W]}
               + {2'b00, b[W-2:MAN_W]} - BIAS;
         ma1_d = {1'b1, a[MAN_W-1:0]};
         mb1_d = {1'b1, b[MAN_W-1:0]};
         rm1_d = rm_e'(rm);
         sp1_d = 1'b1;
         sw1_d = '0;
         sf1_d = '0;
         if (na || nb) begin
            sw1_d = QNAN;
            sf1_d[FL_INV] = (ca == CL_SNAN) || (cb == CL_SNAN);
         end else if ((ia && zb) || (ib && za)) begin
            sw1_d = QNAN;
            sf1_d[FL_INV] = 1'b1;
         end else if (ia || ib) begin
            sw1_d = {sg1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else if (za || zb) begin
            sw1_d = {sg1_d, {(W-1){1'b0}}};
         end else begin
            sp1_d = 1'b0;
         end
      end
   end

   // S2: full significand product.
   always_comb begin
      v2_d  = v2_q;
      sg2_d = sg2_q;
      e2_d  = e2_q;
      p2_d  = p2_q;
      rm2_d = rm2_q;
      sp2_d = sp2_q;
      sw2_d = sw2_q;
      sf2_d = sf2_q;
      if (advance) begin
         v2_d  = v1_q;
         sg2_d = sg1_q;
         e2_d  = e1_q;
         p2_d  = PW'(ma1_q) * PW'(mb1_q);
         rm2_d = rm1_q;
         sp2_d = sp1_q;
         sw2_d = sw1_q;
         sf2_d = sf1_q;
      end
   end

   // S3: normalise the product and extract guard/round/sticky.
   always_comb begin
      if (p2_q[PW-1]) begin
         n_exp = e2_q + EW2'(1);
         n_sig = p2_q[PW-1:MAN_W+1];
         n_g   = p2_q[MAN_W];
         n_r   = p2_q[MAN_W-1];
         n_s   = |p2_q[MAN_W-2:0];
      end else begin
         n_exp = e2_q;
         n_sig = p2_q[PW-2:MAN_W];
         n_g   = p2_q[MAN_W-1];
         n_r   = p2_q[MAN_W-2];
         n_s   = |p2_q[MAN_W-3:0];
      end
   end

   fp_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign   (sg2_q),
      .exp_in (n_exp),
      .sig    (n_sig),
      .g      (n_g),
      .r      (n_r),
      .s      (n_s),
      .rm     (rm2_q),
      .word   (rp_word),
      .flags  (rp_flags)
   );

   // Output register: special-case word wins over rounded result.
   always_comb begin
      ov_d  = ov_q;
      res_d = res_q;
      fl_d  = fl_q;
      if (advance) begin
         ov_d  = v2_q;
         res_d = sp2_q ? sw2_q : rp_word;
         fl_d  = sp2_q ? sf2_q : rp_flags;
      end
   end

   // All stage registers; reset drops in-flight operations.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         sg1_q <= 1'b0;
         e1_q  <= '0;
         ma1_q <= '0;
         mb1_q <= '0;
         rm1_q <= RM_RNE;
         sp1_q <= 1'b0;
         sw1_q <= '0;
         sf1_q <= '0;
         v2_q  <= 1'b0;
         sg2_q <= 1'b0;
         e2_q  <= '0;
         p2_q  <= '0;
         rm2_q <= RM_RNE;
         sp2_q <= 1'b0;
         sw2_q <= '0;
         sf2_q <= '0;
         ov_q  <= 1'b0;
         res_q <= '0;
         fl_q  <= '0;
      end else begin
         v1_q  <= v1_d;
         sg1_q <= sg1_d;
         e1_q  <= e1_d;
         ma1_q <= ma1_d;
         mb1_q <= mb1_d;
         rm1_q <= rm1_d;
         sp1_q <= sp1_d;
         sw1_q <= sw1_d;
         sf1_q <= sf1_d;
         v2_q  <= v2_d;
         sg2_q <= sg2_d;
         e2_q  <= e2_d;
         p2_q  <= p2_d;
         rm2_q <= rm2_d;
         sp2_q <= sp2_d;
         sw2_q <= sw2_d;
         sf2_q <= sf2_d;
         ov_q  <= ov_d;
         res_q <= res_d;
         fl_q  <= fl_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe (binary32),
// reference model built on exact real arithmetic.
`timescale 1ns/1ps
module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst_n, en, in_valid, in_ready;
   logic        out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [1:0]  rm;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   fp_mult_pipe #(
      .EXP_W (8),
      .MAN_W (23)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  rm;
      logic [31:0] res;
      logic [3:0]  fl;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   bp_mode = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic real pow2(input int k);
      real r;
      r = 1.0;
      if (k >= 0) repeat (k) r = r * 2.0;
      else repeat (-k) r = r / 2.0;
      return r;
   endfunction

   // Exact product in double precision, then rounded to binary32.
   function automatic void model(input logic [31:0] xa,
                                 input logic [31:0] xb,
                                 input logic [1:0] xrm,
                                 output logic [31:0] res,
                                 output logic [3:0] fl);
      bit  sg, na, nb, sna, snb, ia, ib, za, zb, up, inx;
      int  ea, eb, e, be, mant;
      real p, sc, fr;
      logic [31:0] bev, mv;
      sg  = xa[31] ^ xb[31];
      ea  = int'(xa[30:23]);
      eb  = int'(xb[30:23]);
      na  = (ea == 255) && (xa[22:0] != 0);
      nb  = (eb == 255) && (xb[22:0] != 0);
      sna = na && !xa[22];
      snb = nb && !xb[22];
      ia  = (ea == 255) && (xa[22:0] == 0);
      ib  = (eb == 255) && (xb[22:0] == 0);
      za  = (ea == 0);
      zb  = (eb == 0);
      res = '0;
      fl  = '0;
      if (na || nb) begin
         res = 32'h7FC00000;
         fl[3] = sna || snb;
         return;
      end
      if ((ia && zb) || (ib && za)) begin
         res = 32'h7FC00000;
         fl[3] = 1'b1;
         return;
      end
      if (ia || ib) begin
         res = {sg, 8'hFF, 23'h0};
         return;
      end
      if (za || zb) begin
         res = {sg, 31'h0};
         return;
      end
      p = real'(int'({1'b1, xa[22:0]})) * real'(int'({1'b1, xb[22:0]}))
          * pow2(ea + eb - 300);
      e = ea + eb - 254;
      if (p >= pow2(e + 1)) e++;
      sc   = p * pow2(23 - e);
      mant = $rtoi($floor(sc));
      fr   = sc - real'(mant);
      inx  = (fr != 0.0);
      case (xrm)
         2'd0:    up = (fr > 0.5) || ((fr == 0.5) && (mant % 2 == 1));
         2'd1:    up = 1'b0;
         2'd2:    up = !sg && inx;
         default: up = sg && inx;
      endcase
      mant = mant + int'(up);
      if (mant == (1 << 24)) begin
         mant = 1 << 23;
         e++;
      end
      be = e + 127;
      if (be < 1) begin
         res = {sg, 31'h0};
         fl  = 4'b0011;
      end else if (be >= 255) begin
         fl = 4'b0101;
         if (xrm == 2'd0 || (xrm == 2'd2 && !sg) || (xrm == 2'd3 && sg))
            res = {sg, 8'hFF, 23'h0};
         else
            res = {sg, 8'hFE, 23'h7FFFFF};
      end else begin
         bev = 32'(be);
         mv  = 32'(mant);
         res = {sg, bev[7:0], mv[22:0]};
         fl  = {3'b000, inx};
      end
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int sel;
      v   = $urandom;
      sel = $urandom_range(0, 15);
      case (sel)
         0: v[30:0] = '0;
         1: v[30:0] = {8'hFF, 23'h0};
         2: begin
            v[30:23] = 8'hFF;
            if (v[22:0] == 0) v[0] = 1'b1;
         end
         3: v[30:23] = 8'h00;
         4: v[22:0] = 23'h7FFFFF;
         default: ;
      endcase
      if (sel >= 4) begin
         if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
         if (v[30:23] == 8'h00) v[30:23] = 8'h01;
      end
      return v;
   endfunction

   task automatic drive_ready();
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                        input logic [1:0] xrm);
      exp_t e;
      bit   done;
      done = 1'b0;
      e.a  = xa;
      e.b  = xb;
      e.rm = xrm;
      model(xa, xb, xrm, e.res, e.fl);
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         drive_ready();
         in_valid = 1'b1;
         a  = xa;
         b  = xb;
         rm = xrm;
         #1;
         if (in_ready) begin
            sb_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
      end
      if (!done) check("issue_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         drive_ready();
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && sb_q.size() > 0; c++) idle(1);
      idle(1);
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: a transfer completes on any cycle presenting valid&&ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && en && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out", {28'd0, flags, result}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("out %h*%h rm%0d", e.a, e.b, e.rm),
                     {28'd0, flags, result}, {28'd0, e.fl, e.res});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bpa [5];
      logic [31:0] bpb [5];
      exp_t e;
      int lat, acc, c0;
      bit found;

      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; rm = 2'd0;
      idle(3);
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Latency of an isolated op.
      issue(32'h40400000, 32'h40000000, 2'd0);
      lat = 0;
      found = 1'b0;
      for (int k = 1; k <= 8 && !found; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #2;
         if (out_valid) begin
            found = 1'b1;
            lat = k;
         end
      end
      check("latency", 64'(lat), 64'd3);
      drain();

      issue(32'h4234851F, 32'h427C851F, 2'd0);
      drain();

      // Back-to-back stream, one accept per cycle.
      issue(32'h3F800000, 32'hBF800000, 2'd0);
      c0 = cyc;
      issue(32'hC1526666, 32'h00000000, 2'd0);
      issue(32'h40400000, 32'hC0000000, 2'd1);
      issue(32'h3FC00000, 32'h3FC00000, 2'd2);
      issue(32'h3F800001, 32'h3F800001, 2'd3);
      check("throughput", 64'(cyc - c0), 64'd4);
      drain();

      // Special values and overflow by rounding mode.
      issue(32'h7F800000, 32'h00000000, 2'd0);
      issue(32'h7F800000, 32'h7F800000, 2'd0);
      issue(32'h00800000, 32'h00180000, 2'd0);
      issue(32'h7F800001, 32'h3F800000, 2'd0);
      issue(32'h7F000000, 32'h40000000, 2'd0);
      issue(32'h7F000000, 32'h40000000, 2'd1);
      issue(32'hFF000000, 32'h40000000, 2'd3);
      issue(32'h00800000, 32'h3F000000, 2'd0);
      drain();

      // Backpressure: only three ops fit while the output is stalled.
      for (int i = 0; i < 5; i++) begin
         bpa[i] = 32'h3F800000 + 32'(i << 20);
         bpb[i] = 32'h40000000 + 32'(i);
      end
      bp_mode = 1;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive_ready();
         in_valid = (acc < 5);
         if (acc < 5) begin
            a  = bpa[acc];
            b  = bpb[acc];
            rm = 2'd0;
            #1;
            if (in_ready) begin
               e.a = a; e.b = b; e.rm = rm;
               model(a, b, rm, e.res, e.fl);
               sb_q.push_back(e);
               acc++;
            end
         end
      end
      check("bp_accepted", 64'(acc), 64'd3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #2;
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_result", 64'(result), 64'(sb_q[0].res));
      end
      bp_mode = 0;
      while (acc < 5) begin
         issue(bpa[acc], bpb[acc], 2'd0);
         acc++;
      end
      drain();

      // Enable low freezes the pipe and blocks input.
      issue(32'h40A00000, 32'h40A00000, 2'd0);
      issue(32'hC0A00000, 32'h3E000000, 2'd0);
      @(negedge clk);
      en = 1'b0;
      in_valid = 1'b1;
      #1;
      check("en_low_in_ready", 64'(in_ready), 64'd0);
      idle(3);
      @(negedge clk);
      en = 1'b1;
      drain();

      // Reset mid-stream drops in-flight ops.
      issue(32'h40000000, 32'h40000000, 2'd0);
      issue(32'h40400000, 32'h40400000, 2'd0);
      issue(32'h40800000, 32'h40800000, 2'd0);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      sb_q.delete();
      @(negedge clk);
      #2;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_flags", 64'(flags), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised stream with random backpressure.
      bp_mode = 2;
      for (int i = 0; i < 400; i++)
         issue(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
      bp_mode = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
